// File: rtl/tweezer_multiaxis_pi_if.sv
// Measurement/parameter input bus and controller output bus of the multi-axis PI core.
// The master drives measurements, setpoints and gains; the slave returns outputs.
interface tweezer_multiaxis_pi_if #(
    parameter int NUM_AXES = 3,
    parameter int IN_W     = 16,
    parameter int COEFF_W  = 10,
    parameter int OUT_W    = 16
);
    logic [NUM_AXES*IN_W-1:0]    in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [NUM_AXES*IN_W-1:0]    setpoint;
    logic [NUM_AXES*COEFF_W-1:0] kp;
    logic [NUM_AXES*COEFF_W-1:0] ki;
    logic [NUM_AXES*OUT_W-1:0]   out_data;
    logic                        out_valid;
    logic [NUM_AXES-1:0]         sat_flags;

    modport master (
        output in_data, in_valid, setpoint, kp, ki,
        input  in_ready, out_data, out_valid, sat_flags
    );

    modport slave (
        input  in_data, in_valid, setpoint, kp, ki,
        output in_ready, out_data, out_valid, sat_flags
    );
endinterface

// File: rtl/tweezer_multiaxis_pi.sv
// Time-multiplexed N-axis PI controller sharing one multiplier across axes,
// with output saturation, anti-windup, per-axis enable and a valid/ready input.
module tweezer_multiaxis_pi #(
    parameter int NUM_AXES   = 3,
    parameter int IN_W       = 16,
    parameter int IN_FRAC    = 15,
    parameter int COEFF_W    = 10,
    parameter int COEFF_FRAC = 9,
    parameter int ACC_W      = 24,
    parameter int OUT_W      = 16,
    parameter int OUT_FRAC   = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    tweezer_multiaxis_pi_if.slave     bus,
    input  logic                      pi_reset,
    input  logic [NUM_AXES-1:0]       pi_enable,
    input  logic                      pi_freeze
);
    localparam int CH_W  = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
    localparam int SHIFT = IN_FRAC - OUT_FRAC;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_AXES - 1);
    localparam logic signed [ACC_W+1:0] Y_MAX = {{(ACC_W+3-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W+1:0] Y_MIN = {{(ACC_W+3-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   I_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   I_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ERR, MULP, MULI, SUM, DONE} state_e;

    state_e state_q, state_d;
    logic [CH_W-1:0]               ch_q, ch_d;
    logic [NUM_AXES*IN_W-1:0]      meas_q, meas_d, sp_q, sp_d;
    logic [NUM_AXES*COEFF_W-1:0]   kp_q, kp_d, ki_q, ki_d;
    logic signed [ACC_W-1:0]       e_q, e_d, p_q, p_d, iinc_q, iinc_d;
    logic signed [ACC_W-1:0]       integ_q [NUM_AXES];
    logic signed [ACC_W-1:0]       integ_d [NUM_AXES];
    logic [NUM_AXES*OUT_W-1:0]     shadow_q, shadow_d, out_data_q, out_data_d;
    logic [NUM_AXES-1:0]           shadow_sat_q, shadow_sat_d, sat_flags_q, sat_flags_d;

    logic [IN_W-1:0]               sp_sel, meas_sel;
    logic [COEFF_W-1:0]            mul_coeff;
    logic signed [ACC_W+COEFF_W:0] prod;
    logic signed [ACC_W-1:0]       mul_res, integ_cur, integ_sat;
    logic signed [ACC_W:0]         i_new;
    logic signed [ACC_W+1:0]       u_w, y_w;
    logic                          clamp_hi, clamp_lo, windup;
    logic [OUT_W-1:0]              ax_y;
    logic                          ax_sat;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every comb output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = ERR;
            ERR:     state_d = MULP;
            MULP:    state_d = MULI;
            MULI:    state_d = SUM;
            SUM:     state_d = (ch_q == LAST_CH) ? DONE : ERR;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    assign bus.out_data  = out_data_q;
    assign bus.sat_flags = sat_flags_q;

    // Shared datapath: one multiplier serves both gains, selected by state.
    always_comb begin
        sp_sel    = sp_q[int'(ch_q)*IN_W +: IN_W];
        meas_sel  = meas_q[int'(ch_q)*IN_W +: IN_W];
        mul_coeff = (state_q == MULP) ? kp_q[int'(ch_q)*COEFF_W +: COEFF_W]
                                      : ki_q[int'(ch_q)*COEFF_W +: COEFF_W];
        prod      = e_q * $signed({1'b0, mul_coeff});
        mul_res   = ACC_W'(prod >>> COEFF_FRAC);

        integ_cur = integ_q[ch_q];
        i_new     = (ACC_W+1)'(integ_cur) + (ACC_W+1)'(iinc_q);
        integ_sat = (i_new > I_MAX) ? ACC_W'(I_MAX) :
                    (i_new < I_MIN) ? ACC_W'(I_MIN) : i_new[ACC_W-1:0];
        u_w       = (ACC_W+2)'(p_q) + (ACC_W+2)'(i_new);
        y_w       = u_w >>> SHIFT;
        clamp_hi  = (y_w > Y_MAX);
        clamp_lo  = (y_w < Y_MIN);
        // Hold the integrator only when it is pushing further into the clamp.
        windup    = (clamp_hi && !iinc_q[ACC_W-1] && (iinc_q != '0)) ||
                    (clamp_lo && iinc_q[ACC_W-1]);
    end

    always_comb begin
        ch_d         = ch_q;
        meas_d       = meas_q;
        sp_d         = sp_q;
        kp_d         = kp_q;
        ki_d         = ki_q;
        e_d          = e_q;
        p_d          = p_q;
        iinc_d       = iinc_q;
        integ_d      = integ_q;
        shadow_d     = shadow_q;
        shadow_sat_d = shadow_sat_q;
        out_data_d   = out_data_q;
        sat_flags_d  = sat_flags_q;
        ax_y         = '0;
        ax_sat       = 1'b0;

        case (state_q)
            IDLE: if (bus.in_valid) begin
                meas_d = bus.in_data;
                sp_d   = bus.setpoint;
                kp_d   = bus.kp;
                ki_d   = bus.ki;
                ch_d   = '0;
            end
            ERR:  e_d    = ACC_W'($signed(sp_sel)) - ACC_W'($signed(meas_sel));
            MULP: p_d    = mul_res;
            MULI: iinc_d = mul_res;
            SUM: begin
                if (!pi_enable[ch_q]) begin
                    integ_d[ch_q] = '0;
                end else begin
                    ax_sat = clamp_hi || clamp_lo;
                    ax_y   = clamp_hi ? OUT_W'(Y_MAX) :
                             clamp_lo ? OUT_W'(Y_MIN) : y_w[OUT_W-1:0];
                    if (!pi_freeze && !windup) integ_d[ch_q] = integ_sat;
                end
                shadow_d[int'(ch_q)*OUT_W +: OUT_W] = ax_y;
                shadow_sat_d[ch_q]                  = ax_sat;
                if (ch_q == LAST_CH) begin
                    out_data_d  = shadow_d;
                    sat_flags_d = shadow_sat_d;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            default: ;
        endcase

        if (pi_reset) begin
            for (int k = 0; k < NUM_AXES; k++) integ_d[k] = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q         <= '0;
            meas_q       <= '0;
            sp_q         <= '0;
            kp_q         <= '0;
            ki_q         <= '0;
            e_q          <= '0;
            p_q          <= '0;
            iinc_q       <= '0;
            // NOTE: the integrator array is reset explicitly; a stale integral would kick the trap.
            for (int k = 0; k < NUM_AXES; k++) integ_q[k] <= '0;
            shadow_q     <= '0;
            shadow_sat_q <= '0;
            out_data_q   <= '0;
            sat_flags_q  <= '0;
        end else begin
            ch_q         <= ch_d;
            meas_q       <= meas_d;
            sp_q         <= sp_d;
            kp_q         <= kp_d;
            ki_q         <= ki_d;
            e_q          <= e_d;
            p_q          <= p_d;
            iinc_q       <= iinc_d;
            integ_q      <= integ_d;
            shadow_q     <= shadow_d;
            shadow_sat_q <= shadow_sat_d;
            out_data_q   <= out_data_d;
            sat_flags_q  <= sat_flags_d;
        end
    end
endmodule

// File: tb/tb_tweezer_multiaxis_pi.sv
// Directed bench for the three-axis PI core: proportional, integral, saturation,
// freeze/reset, enable, busy handshake and mid-vector reset.
module tb_tweezer_multiaxis_pi;
    localparam int NA = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          pi_reset;
    logic          pi_freeze;
    logic [NA-1:0] pi_enable;

    tweezer_multiaxis_pi_if #(.NUM_AXES(NA), .IN_W(16), .COEFF_W(10), .OUT_W(16)) bus ();

    tweezer_multiaxis_pi #(.NUM_AXES(NA)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .pi_reset  (pi_reset),
        .pi_enable (pi_enable),
        .pi_freeze (pi_freeze)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int sp [NA];
    int meas [NA];
    int kpv [NA];
    int kiv [NA];
    int lat;
    int pulses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] out_ax(input int k);
        return bus.out_data[k*16 +: 16];
    endfunction

    task automatic clear_axes();
        for (int k = 0; k < NA; k++) begin
            sp[k] = 0; meas[k] = 0; kpv[k] = 0; kiv[k] = 0;
        end
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < NA; k++) begin
            bus.setpoint[k*16 +: 16] = 16'(sp[k]);
            bus.in_data[k*16 +: 16]  = 16'(meas[k]);
            bus.kp[k*10 +: 10]       = 10'(kpv[k]);
            bus.ki[k*10 +: 10]       = 10'(kiv[k]);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) check("idle_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    // Called at a negedge; returns at the negedge of the out_valid cycle.
    task automatic run_vec(output int latency);
        wait_idle();
        drive_inputs();
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        latency = -1;
        for (int n = 1; n <= 40; n++) begin
            if (bus.out_valid) begin
                latency = n;
                break;
            end
            @(negedge clk);
        end
        if (latency < 0) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset        = 1'b1;
        pi_reset     = 1'b0;
        pi_freeze    = 1'b0;
        pi_enable    = 3'b111;
        bus.in_valid = 1'b0;
        clear_axes();
        drive_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_sat",       32'(bus.sat_flags), 32'd0);

        // Proportional on ax0, unity gain on ax1, hard positive clamp on ax2
        kpv[0] = 256;  meas[0] = 16'h2000;
        kpv[1] = 512;  sp[1]   = 16'h1000;
        kpv[2] = 1023; sp[2]   = 16'h7FFF; meas[2] = 16'h8000;
        run_vec(lat);
        check("p_latency", 32'(lat), 32'd13);
        check("p_out0", 32'(out_ax(0)), 32'h0000F000);
        check("p_out1", 32'(out_ax(1)), 32'h00001000);
        check("p_out2", 32'(out_ax(2)), 32'h00007FFF);
        check("p_sat",  32'(bus.sat_flags), 32'b100);
        repeat (4) @(negedge clk);
        check("hold_out0",  32'(out_ax(0)), 32'h0000F000);
        check("hold_valid", 32'(bus.out_valid), 32'd0);

        // e = -1 with gain 0.5 must round toward -inf, not toward zero
        clear_axes();
        kpv[0] = 256; meas[0] = 1;
        run_vec(lat);
        check("trunc_out0", 32'(out_ax(0)), 32'h0000FFFF);
        check("trunc_sat",  32'(bus.sat_flags), 32'd0);

        // Integral accumulation to the positive rail
        clear_axes();
        kiv[0] = 128; meas[0] = 16'hE000;
        for (int v = 1; v <= 15; v++) begin
            run_vec(lat);
            check($sformatf("integ_v%0d", v), 32'(out_ax(0)), 32'(v * 16'h0800));
        end
        run_vec(lat);
        check("sat_out0",  32'(out_ax(0)), 32'h00007FFF);
        check("sat_flag0", 32'(bus.sat_flags), 32'b001);
        run_vec(lat);
        check("windup_out0", 32'(out_ax(0)), 32'h00007FFF);
        meas[0] = 16'h2000;
        run_vec(lat);
        check("unwind_out0", 32'(out_ax(0)), 32'h00007000);
        check("unwind_sat",  32'(bus.sat_flags), 32'd0);

        // Freeze holds the integrator at 0x7000
        meas[0]   = 16'hE000;
        pi_freeze = 1'b1;
        run_vec(lat);
        check("freeze_a", 32'(out_ax(0)), 32'h00007800);
        run_vec(lat);
        check("freeze_b", 32'(out_ax(0)), 32'h00007800);
        pi_freeze = 1'b0;
        @(negedge clk);
        pi_reset = 1'b1;
        @(negedge clk);
        pi_reset = 1'b0;
        meas[0]  = 0;
        run_vec(lat);
        check("pireset_out0", 32'(out_ax(0)), 32'h00000000);

        // Per-axis enable: axis 1 disabled
        clear_axes();
        pi_enable = 3'b101;
        kpv[0] = 512; sp[0] = 16'h0100;
        kpv[1] = 512; kiv[1] = 128; sp[1] = 16'h0200;
        kpv[2] = 512; meas[2] = 16'h0300;
        run_vec(lat);
        check("en_out0", 32'(out_ax(0)), 32'h00000100);
        check("en_out1", 32'(out_ax(1)), 32'h00000000);
        check("en_out2", 32'(out_ax(2)), 32'h0000FD00);

        // in_valid held during the busy window must not start a second vector
        wait_idle();
        drive_inputs();
        bus.in_valid = 1'b1;
        @(posedge clk);
        pulses = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 3) check("busy_ready", 32'(bus.in_ready), 32'd0);
            if (n == 9) bus.in_valid = 1'b0;
            if (bus.out_valid) pulses++;
        end
        check("busy_pulses", 32'(pulses), 32'd1);
        pi_enable = 3'b111;

        // Reset in the middle of a vector
        clear_axes();
        kiv[0] = 128; meas[0] = 16'hE000;
        run_vec(lat);
        check("pre_abort_out0", 32'(out_ax(0)), 32'h00000800);
        wait_idle();
        drive_inputs();
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus.out_valid) pulses++;
            @(negedge clk);
        end
        check("abort_pulses",   32'(pulses), 32'd0);
        check("abort_out_data", 32'(bus.out_data), 32'd0);
        check("abort_sat",      32'(bus.sat_flags), 32'd0);
        check("abort_ready",    32'(bus.in_ready), 32'd1);
        run_vec(lat);
        check("post_abort_lat",  32'(lat), 32'd13);
        check("post_abort_out0", 32'(out_ax(0)), 32'h00000800);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
